// File: rtl/ibex_sram_arbiter_if.sv
// Host-side and SRAM-side bus bundle for the two-host SRAM arbiter.
// slave = arbiter view, master = hosts + SRAM view.
interface ibex_sram_arbiter_if #(
    parameter int AddrW = 9
);
    logic             instr_req_i;
    logic [31:0]      instr_addr_i;
    logic             instr_gnt_o;
    logic             instr_rvalid_o;
    logic [31:0]      instr_rdata_o;
    logic             instr_err_o;

    logic             data_req_i;
    logic             data_we_i;
    logic [3:0]       data_be_i;
    logic [31:0]      data_addr_i;
    logic [31:0]      data_wdata_i;
    logic             data_gnt_o;
    logic             data_rvalid_o;
    logic [31:0]      data_rdata_o;
    logic             data_err_o;

    logic             mem_req_o;
    logic             mem_we_o;
    logic [3:0]       mem_be_o;
    logic [AddrW-1:0] mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic [31:0]      mem_rdata_i;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o,
        output instr_rdata_o, instr_err_o,
        input  data_req_i, data_we_i, data_be_i,
        input  data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o,
        output data_rdata_o, data_err_o,
        output mem_req_o, mem_we_o, mem_be_o,
        output mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o,
        input  instr_rdata_o, instr_err_o,
        output data_req_i, data_we_i, data_be_i,
        output data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o,
        input  data_rdata_o, data_err_o,
        input  mem_req_o, mem_we_o, mem_be_o,
        input  mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/ibex_sram_arbiter.sv
// Round-robin arbiter joining Ibex instr/data ports onto one ram_1p,
// with out-of-range decode error and a 1-deep overlapped response stage.
module ibex_sram_arbiter #(
    parameter int          MemSize  = 2048,
    parameter logic [31:0] MemStart = 32'h0000_0000
) (
    input logic           clk_sys,
    input logic           rst_sys_n,
    ibex_sram_arbiter_if.slave bus
);
    localparam int AddrW = $clog2(MemSize / 4);
    localparam logic [31:0] HiMask = ~(32'(MemSize) - 32'd1);

    typedef enum logic {
        HOST_I = 1'b0,
        HOST_D = 1'b1
    } host_e;

    host_e       last_q, last_d;
    host_e       own_q, own_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic        we_q, we_d;

    logic        any_req;
    logic        sel_d;
    logic        hit;
    logic [31:0] addr;
    logic        rd_ok;

    always_comb begin
        any_req = bus.instr_req_i | bus.data_req_i;
        // data wins unless instr also asks and data was served last
        sel_d   = bus.data_req_i &
                  (~bus.instr_req_i | (last_q == HOST_I));
        addr    = sel_d ? bus.data_addr_i : bus.instr_addr_i;
        hit     = ((addr & HiMask) == MemStart);

        bus.instr_gnt_o = any_req & ~sel_d;
        bus.data_gnt_o  = sel_d;

        bus.mem_req_o   = any_req & hit;
        bus.mem_we_o    = sel_d & bus.data_we_i;
        bus.mem_be_o    = sel_d ? bus.data_be_i : 4'hF;
        bus.mem_wdata_o = sel_d ? bus.data_wdata_i : 32'h0;
        bus.mem_addr_o  = addr[AddrW+1:2];

        last_d = last_q;
        own_d  = own_q;
        err_d  = err_q;
        we_d   = we_q;
        vld_d  = any_req;
        if (any_req) begin
            last_d = sel_d ? HOST_D : HOST_I;
            own_d  = sel_d ? HOST_D : HOST_I;
            err_d  = ~hit;
            we_d   = sel_d & bus.data_we_i;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            last_q <= HOST_I;
            own_q  <= HOST_I;
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            last_q <= last_d;
            own_q  <= own_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            we_q   <= we_d;
        end
    end

    always_comb begin
        rd_ok = vld_q & ~err_q & ~we_q;

        bus.instr_rvalid_o = vld_q & (own_q == HOST_I);
        bus.instr_err_o    = bus.instr_rvalid_o & err_q;
        bus.instr_rdata_o  = (rd_ok && own_q == HOST_I) ?
                             bus.mem_rdata_i : 32'h0;

        bus.data_rvalid_o  = vld_q & (own_q == HOST_D);
        bus.data_err_o     = bus.data_rvalid_o & err_q;
        bus.data_rdata_o   = (rd_ok && own_q == HOST_D) ?
                             bus.mem_rdata_i : 32'h0;
    end
endmodule

// File: tb/tb_ibex_sram_arbiter.sv
// Directed bench for ibex_sram_arbiter with a behavioural ram_1p
// (1-cycle read latency, byte-enabled writes).
module tb_ibex_sram_arbiter;
    logic clk_sys;
    logic rst_sys_n;
    int   n_chk;
    int   n_bad;

    ibex_sram_arbiter_if #(.AddrW(9)) bus ();

    ibex_sram_arbiter #(
        .MemSize  (2048),
        .MemStart (32'h0000_0000)
    ) u_dut (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .bus       (bus.slave)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic [31:0] mem [512];

    // SRAM contents are reloaded while reset is held
    always @(posedge clk_sys) begin
        if (!rst_sys_n) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
            mem[0]  <= 32'h0000_1111;
            mem[1]  <= 32'h2222_3333;
            mem[2]  <= 32'h4444_5555;
            mem[4]  <= 32'h1122_3344;
            mem[32] <= 32'hDEAD_BEEF;
        end else if (bus.mem_req_o) begin
            if (bus.mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be_o[b])
                        mem[bus.mem_addr_o][8*b +: 8] <=
                            bus.mem_wdata_o[8*b +: 8];
            end else begin
                bus.mem_rdata_i <= mem[bus.mem_addr_o];
            end
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(logic ir, logic [31:0] ia,
                         logic dr, logic dw, logic [3:0] be,
                         logic [31:0] da, logic [31:0] wd);
        bus.instr_req_i  = ir;
        bus.instr_addr_i = ia;
        bus.data_req_i   = dr;
        bus.data_we_i    = dw;
        bus.data_be_i    = be;
        bus.data_addr_i  = da;
        bus.data_wdata_i = wd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic do_reset();
        rst_sys_n = 1'b0;
        idle();
        step();
        step();
        chk("rst_irv", 32'(bus.instr_rvalid_o), 32'h0);
        chk("rst_drv", 32'(bus.data_rvalid_o), 32'h0);
        chk("rst_mreq", 32'(bus.mem_req_o), 32'h0);
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        bus.mem_rdata_i = 32'h0;
        do_reset();

        // single fetch
        step();
        drive(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("f_ig nt", 32'(bus.instr_gnt_o), 32'h1);
        chk("f_dgnt", 32'(bus.data_gnt_o), 32'h0);
        chk("f_mreq", 32'(bus.mem_req_o), 32'h1);
        chk("f_maddr", 32'(bus.mem_addr_o), 32'h20);
        chk("f_mwe", 32'(bus.mem_we_o), 32'h0);
        chk("f_mbe", 32'(bus.mem_be_o), 32'hF);
        step();
        idle();
        chk("f_irv", 32'(bus.instr_rvalid_o), 32'h1);
        chk("f_ird", bus.instr_rdata_o, 32'hDEAD_BEEF);
        chk("f_ierr", 32'(bus.instr_err_o), 32'h0);
        chk("f_drv", 32'(bus.data_rvalid_o), 32'h0);

        // conflict after reset: data, instr, data, instr
        do_reset();
        step();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        chk("c1_dgnt", 32'(bus.data_gnt_o), 32'h1);
        chk("c1_ignt", 32'(bus.instr_gnt_o), 32'h0);
        chk("c1_maddr", 32'(bus.mem_addr_o), 32'h2);
        step();
        chk("c1_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("c1_drd", bus.data_rdata_o, 32'h4444_5555);
        chk("c1_irv", 32'(bus.instr_rvalid_o), 32'h0);
        chk("c2_ignt", 32'(bus.instr_gnt_o), 32'h1);
        chk("c2_dgnt", 32'(bus.data_gnt_o), 32'h0);
        chk("c2_maddr", 32'(bus.mem_addr_o), 32'h0);
        step();
        chk("c2_irv", 32'(bus.instr_rvalid_o), 32'h1);
        chk("c2_ird", bus.instr_rdata_o, 32'h0000_1111);
        chk("c2_drv", 32'(bus.data_rvalid_o), 32'h0);
        chk("c2_drd0", bus.data_rdata_o, 32'h0);
        chk("c3_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        chk("c3_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("c3_irv", 32'(bus.instr_rvalid_o), 32'h0);
        chk("c4_ignt", 32'(bus.instr_gnt_o), 32'h1);
        step();
        chk("c4_irv", 32'(bus.instr_rvalid_o), 32'h1);
        chk("c4_drv", 32'(bus.data_rvalid_o), 32'h0);
        idle();
        #1;
        chk("idle_mreq", 32'(bus.mem_req_o), 32'h0);
        chk("idle_gnt", 32'({bus.instr_gnt_o, bus.data_gnt_o}), 32'h0);
        step();
        chk("idle_rv", 32'({bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);

        // byte write then read back
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_AB00);
        #1;
        chk("w_dgnt", 32'(bus.data_gnt_o), 32'h1);
        chk("w_mreq", 32'(bus.mem_req_o), 32'h1);
        chk("w_mwe", 32'(bus.mem_we_o), 32'h1);
        chk("w_mbe", 32'(bus.mem_be_o), 32'h2);
        chk("w_mwd", bus.mem_wdata_o, 32'h0000_AB00);
        chk("w_maddr", 32'(bus.mem_addr_o), 32'h4);
        step();
        chk("w_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("w_derr", 32'(bus.data_err_o), 32'h0);
        chk("w_drd", bus.data_rdata_o, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1;
        chk("r_mwe", 32'(bus.mem_we_o), 32'h0);
        chk("r_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        chk("r_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("r_drd", bus.data_rdata_o, 32'h1122_AB44);

        // zero-byte-enable write is a no-op but still responds
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF);
        #1;
        chk("z_mbe", 32'(bus.mem_be_o), 32'h0);
        chk("z_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        chk("z_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("z_derr", 32'(bus.data_err_o), 32'h0);

        // out-of-range read
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        #1;
        chk("o_dgnt", 32'(bus.data_gnt_o), 32'h1);
        chk("o_mreq", 32'(bus.mem_req_o), 32'h0);
        step();
        chk("o_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("o_derr", 32'(bus.data_err_o), 32'h1);
        chk("o_drd", bus.data_rdata_o, 32'h0);

        // back-to-back reads 0x0, 0x4, 0x8
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        #1;
        chk("t0_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        chk("t0_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("t0_drd", bus.data_rdata_o, 32'h0000_1111);
        chk("t0_derr", 32'(bus.data_err_o), 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        #1;
        chk("t1_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        chk("t1_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("t1_drd", bus.data_rdata_o, 32'h2222_3333);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        chk("t2_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        chk("t2_drv", 32'(bus.data_rvalid_o), 32'h1);
        chk("t2_drd", bus.data_rdata_o, 32'h4444_5555);

        // reset the cycle after a data grant
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        #1;
        chk("m_dgnt", 32'(bus.data_gnt_o), 32'h1);
        step();
        rst_sys_n = 1'b0;
        idle();
        #1;
        chk("m_drv", 32'(bus.data_rvalid_o), 32'h0);
        chk("m_irv", 32'(bus.instr_rvalid_o), 32'h0);
        step();
        @(negedge clk_sys);
        rst_sys_n = 1'b1;
        step();
        chk("m_rv2", 32'({bus.instr_rvalid_o, bus.data_rvalid_o}), 32'h0);
        drive(1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        #1;
        chk("m_dwin", 32'(bus.data_gnt_o), 32'h1);
        chk("m_iloss", 32'(bus.instr_gnt_o), 32'h0);
        step();
        idle();
        chk("m_drv3", 32'(bus.data_rvalid_o), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
